// File: rtl/vec_relu_arbiter.sv
// vec_relu_arbiter: round-robin share of one vector ReLU between two requesters.
// Result is registered and tagged with its source (0 = A, 1 = B).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   a_valid/a_ready/a_data  requester A handshake and vector
//   b_valid/b_ready/b_data  requester B handshake and vector
//   out_valid/out_ready     registered output handshake
//   out_data/out_src        ReLU result and its source
module vec_relu_arbiter #(
  parameter int VEC_SIZE   = 4,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  localparam int FW = 1 + EXP_WIDTH + MANT_WIDTH,
  localparam int VW = VEC_SIZE * FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [VW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [VW-1:0] b_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_data,
  output logic          out_src
);

  // last: source of the most recent accept (0 = A, 1 = B)
  logic          last;
  logic          can_take;
  logic          grant_a;
  logic          grant_b;
  logic          take_a;
  logic          take_b;
  logic [VW-1:0] sel_data;
  logic [VW-1:0] relu_vec;

  assign can_take = !out_valid || out_ready;

  // Grant only ever goes to a valid requester; a tie
  // goes to whoever did not win last time.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      (a_valid && !b_valid): grant_a = 1'b1;
      (!a_valid && b_valid): grant_b = 1'b1;
      (a_valid && b_valid): begin
        grant_a = last;
        grant_b = !last;
      end
      default: ;
    endcase
  end

  // rst_n gating keeps readies low for the whole reset,
  // even though out_valid = 0 makes can_take true then.
  assign a_ready = rst_n && can_take && grant_a;
  assign b_ready = rst_n && can_take && grant_b;

  assign take_a = a_valid && a_ready;
  assign take_b = b_valid && b_ready;

  assign sel_data = take_b ? b_data : a_data;

  // Negative sign (incl. -0, -Inf, -NaN) -> +0.0;
  // everything else passes unchanged.
  always_comb begin
    relu_vec = sel_data;
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (sel_data[i*FW + FW - 1]) begin
        relu_vec[i*FW +: FW] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      last      <= 1'b1;
    end else if (take_a || take_b) begin
      out_valid <= 1'b1;
      out_data  <= relu_vec;
      out_src   <= take_b;
      last      <= take_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_relu_arbiter.sv
// tb_vec_relu_arbiter: directed bench for vec_relu_arbiter.
// Linear stimulus; hand-computed expected values.
module tb_vec_relu_arbiter;

  localparam int VW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [VW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [VW-1:0] b_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          out_src;

  int checks = 0;
  int errors = 0;

  vec_relu_arbiter #(
    .VEC_SIZE(4),
    .EXP_WIDTH(8),
    .MANT_WIDTH(23)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_data(b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] a1_in, a1_ex, b1_in, b1_ex;
  logic [VW-1:0] a0_in, a0_ex, b2_in, b2_ex;
  logic [VW-1:0] s_in, s_ex;
  logic [31:0]   e;

  initial begin
    a0_in = {32'hBF800000, 32'h3F800000,
             32'h80000000, 32'h7FC00000};
    a0_ex = {32'h00000000, 32'h3F800000,
             32'h00000000, 32'h7FC00000};
    a1_in = {32'h40000000, 32'hC0000000,
             32'hFF800000, 32'h7F800000};
    a1_ex = {32'h40000000, 32'h00000000,
             32'h00000000, 32'h7F800000};
    b1_in = {32'hFFC00001, 32'h00000001,
             32'h80000001, 32'h3F000000};
    b1_ex = {32'h00000000, 32'h00000001,
             32'h00000000, 32'h3F000000};
    b2_in = {32'h12345678, 32'h87654321,
             32'h00000000, 32'hFFFFFFFF};
    b2_ex = {32'h12345678, 32'h00000000,
             32'h00000000, 32'h00000000};

    rst_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = a1_in;
    b_data = b1_in;
    out_ready = 1'b1;

    // reset state, readies forced low
    #3;
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", VW'(out_src), VW'(0));
    chk("rst_a_ready", VW'(a_ready), VW'(0));
    chk("rst_b_ready", VW'(b_ready), VW'(0));
    a_valid = 1'b0;
    b_valid = 1'b0;
    #9;
    rst_n = 1'b1;
    tick();

    // 1: A only
    a_valid = 1'b1;
    a_data = a0_in;
    #1;
    chk("t1_a_ready", VW'(a_ready), VW'(1));
    chk("t1_b_ready", VW'(b_ready), VW'(0));
    tick();
    a_valid = 1'b0;
    chk("t1_out_valid", VW'(out_valid), VW'(1));
    chk("t1_out_data", out_data, a0_ex);
    chk("t1_out_src", VW'(out_src), VW'(0));

    // re-reset so the tie test starts from reset
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // 2: tie, strict alternation A,B,A,B
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = a1_in;
    b_data = b1_in;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_a_ready%0d", k),
          VW'(a_ready), VW'(k % 2 == 0));
      chk($sformatf("t2_b_ready%0d", k),
          VW'(b_ready), VW'(k % 2 == 1));
      tick();
      chk($sformatf("t2_src%0d", k),
          VW'(out_src), VW'(k % 2));
      chk($sformatf("t2_data%0d", k), out_data,
          (k % 2 == 0) ? a1_ex : b1_ex);
    end

    // 3: backpressure holds B's result
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_a_ready%0d", k),
          VW'(a_ready), VW'(0));
      chk($sformatf("t3_b_ready%0d", k),
          VW'(b_ready), VW'(0));
      tick();
      chk($sformatf("t3_valid%0d", k),
          VW'(out_valid), VW'(1));
      chk($sformatf("t3_data%0d", k), out_data, b1_ex);
      chk($sformatf("t3_src%0d", k),
          VW'(out_src), VW'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("t3_rel_a_ready", VW'(a_ready), VW'(1));
    chk("t3_rel_b_ready", VW'(b_ready), VW'(0));
    tick();
    chk("t3_rel_valid", VW'(out_valid), VW'(1));
    chk("t3_rel_src", VW'(out_src), VW'(0));
    chk("t3_rel_data", out_data, a1_ex);

    // 4: drain and accept B in the same cycle
    a_valid = 1'b0;
    b_data = b2_in;
    #1;
    chk("t4_b_ready", VW'(b_ready), VW'(1));
    chk("t4_a_ready", VW'(a_ready), VW'(0));
    tick();
    b_valid = 1'b0;
    chk("t4_valid", VW'(out_valid), VW'(1));
    chk("t4_data", out_data, b2_ex);
    chk("t4_src", VW'(out_src), VW'(1));
    tick();
    chk("t4_drained", VW'(out_valid), VW'(0));

    // 5: async reset mid-stream
    a_valid = 1'b1;
    a_data = a1_in;
    tick();
    a_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_held", VW'(out_valid), VW'(1));
    a_valid = 1'b1;
    b_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", VW'(out_valid), VW'(0));
    chk("t5_rst_data", out_data, '0);
    chk("t5_rst_a_ready", VW'(a_ready), VW'(0));
    chk("t5_rst_b_ready", VW'(b_ready), VW'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_tie_a_ready", VW'(a_ready), VW'(1));
    chk("t5_tie_b_ready", VW'(b_ready), VW'(0));
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("t5_tie_src", VW'(out_src), VW'(0));
    chk("t5_tie_data", out_data, a1_ex);

    // 6: B streams 8 vectors, A idle
    b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        e = 32'h3F800000 + 32'(i * 16 + j);
        if ((i + j) % 3 == 0) begin
          e[31] = 1'b1;
        end
        s_in[j*32 +: 32] = e;
        s_ex[j*32 +: 32] = e[31] ? 32'h0 : e;
      end
      b_data = s_in;
      #1;
      chk($sformatf("t6_b_ready%0d", i),
          VW'(b_ready), VW'(1));
      chk($sformatf("t6_a_ready%0d", i),
          VW'(a_ready), VW'(0));
      tick();
      chk($sformatf("t6_valid%0d", i),
          VW'(out_valid), VW'(1));
      chk($sformatf("t6_src%0d", i),
          VW'(out_src), VW'(1));
      chk($sformatf("t6_data%0d", i), out_data, s_ex);
    end
    b_valid = 1'b0;
    tick();
    chk("t6_drained", VW'(out_valid), VW'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
